// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multicycle control sequencer and its datapath:
// state encoding, next-PC selects, opcodes, memory access codes, decode helpers.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    S_BOOT      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  localparam logic [1:0] PCSEL_SEQ  = 2'd0;
  localparam logic [1:0] PCSEL_JAL  = 2'd1;
  localparam logic [1:0] PCSEL_JALR = 2'd2;
  localparam logic [1:0] PCSEL_BR   = 2'd3;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] MT_B  = 3'b000;
  localparam logic [2:0] MT_H  = 3'b001;
  localparam logic [2:0] MT_W  = 3'b010;
  localparam logic [2:0] MT_BU = 3'b100;
  localparam logic [2:0] MT_HU = 3'b110;

  function automatic logic inst_legal(input logic [9:0] inst);
    logic [2:0] f3;
    f3 = inst[9:7];
    case (inst[6:0])
      OP_LOAD:  return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                       (f3 == 3'b100) || (f3 == 3'b101);
      OP_STORE: return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_IMM, OP_REG: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

  // Only called for legal loads/stores; LHU is the one funct3 that is remapped.
  function automatic logic [2:0] mem_type_of(input logic [9:0] inst);
    case (inst[9:7])
      3'b000:  return MT_B;
      3'b001:  return MT_H;
      3'b100:  return MT_BU;
      3'b101:  return MT_HU;
      default: return MT_W;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_sequencer_mem_watchdog.sv
// Wait-cycle counter for one memory request; flags the cycle in which the
// TIMEOUT-th consecutive wait cycle occurs without a ready.
module mem_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic clear,
  input  logic count,
  input  logic ready,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                cnt <= 8'd0;
    else if (clear)           cnt <= 8'd0;
    else if (count && !ready) cnt <= cnt + 8'd1;
  end

  // A ready in the final allowed cycle still completes the request.
  assign expired = count && !ready && (cnt == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Control FSM for a multicycle RV32 core: fetch/decode/execute/memory/writeback
// sequencing with illegal-instruction and memory-timeout traps.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic [9:0] INST,
  input  logic       MEM_READY,
  input  logic       BRANCH_TAKEN,
  output logic       MEM_REQ,
  output logic       MEM_IS_FETCH,
  output logic       write_enable,
  output logic [2:0] mem_type,
  output logic       IR_WRITE,
  output logic       PC_WRITE,
  output logic [1:0] PC_SEL,
  output logic       Reg_WRITE,
  output logic       RETIRE,
  output logic       ILLEGAL,
  output logic       TIMED_OUT,
  output logic [2:0] STATE
);

  state_t state, nxt;
  logic   timed_out_q;
  logic   expired, wd_clear, wd_count;
  logic   is_load, is_store;

  assign is_load  = (INST[6:0] == OP_LOAD);
  assign is_store = (INST[6:0] == OP_STORE);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= S_BOOT;
      timed_out_q <= 1'b0;
    end else begin
      state <= nxt;
      if (expired) timed_out_q <= 1'b1;
    end
  end

  always_comb begin
    nxt          = state;
    MEM_REQ      = 1'b0;
    MEM_IS_FETCH = 1'b0;
    write_enable = 1'b0;
    mem_type     = 3'b000;
    IR_WRITE     = 1'b0;
    PC_WRITE     = 1'b0;
    PC_SEL       = PCSEL_SEQ;
    Reg_WRITE    = 1'b0;
    RETIRE       = 1'b0;
    ILLEGAL      = 1'b0;
    case (state)
      S_BOOT: nxt = S_FETCH;
      S_FETCH: begin
        MEM_REQ      = 1'b1;
        MEM_IS_FETCH = 1'b1;
        mem_type     = MT_W;
        if (MEM_READY) begin
          IR_WRITE = 1'b1;
          nxt      = S_DECODE;
        end else if (expired) begin
          nxt = S_TRAP;
        end
      end
      S_DECODE: nxt = inst_legal(INST) ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        if (is_load || is_store) begin
          nxt = S_MEMORY;
        end else if (INST[6:0] == OP_BRANCH) begin
          PC_WRITE = 1'b1;
          RETIRE   = 1'b1;
          PC_SEL   = BRANCH_TAKEN ? PCSEL_BR : PCSEL_SEQ;
          nxt      = S_FETCH;
        end else begin
          nxt = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        MEM_REQ      = 1'b1;
        write_enable = is_store;
        mem_type     = mem_type_of(INST);
        if (MEM_READY) begin
          if (is_store) begin
            PC_WRITE = 1'b1;
            RETIRE   = 1'b1;
            nxt      = S_FETCH;
          end else begin
            nxt = S_WRITEBACK;
          end
        end else if (expired) begin
          nxt = S_TRAP;
        end
      end
      S_WRITEBACK: begin
        Reg_WRITE = 1'b1;
        PC_WRITE  = 1'b1;
        RETIRE    = 1'b1;
        if (INST[6:0] == OP_JAL)       PC_SEL = PCSEL_JAL;
        else if (INST[6:0] == OP_JALR) PC_SEL = PCSEL_JALR;
        nxt = S_FETCH;
      end
      S_TRAP:  ILLEGAL = 1'b1;
      default: nxt = S_TRAP;
    endcase
  end

  assign TIMED_OUT = timed_out_q;
  assign STATE     = state;

  // The counter restarts only on a fresh entry into a request state.
  assign wd_count = MEM_REQ;
  assign wd_clear = ((nxt == S_FETCH) || (nxt == S_MEMORY)) && (nxt != state);

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .clear   (wd_clear),
    .count   (wd_count),
    .ready   (MEM_READY),
    .expired (expired)
  );

endmodule
